block_memory: RTL and testbench
===============================

# block_memory

Main data memory that answers block requests from the data cache. It is the responder on the cache-to-memory interface: 64 blocks of 32 bits (four bytes each), block-addressed by a 6-bit address, with a fixed multi-cycle access latency. Stalls are signalled on `busywait`. The block sits in `system` beside the CPU and replaces the behavioural memory model with a cycle-exact, synthesizable FSM.

## Interface
- `LATENCY`, default 5: number of CLK posedges from request capture to access completion; legal range is 1–15.
- `CLK  input  1`: clock; all state changes on the posedge.
- `RESET  input  1`: reset, asynchronous, active-high.
- `read  input  1`: block read request, held high by the cache until it sees `busywait` low.
- `write  input  1`: block write request, same holding rule as `read`.
- `address  input  6`: block address, 0–63.
- `writedata  input  32`: block data to write; byte 0 is in bits [7:0].
- `readdata  output  32`: last block read; valid from DONE onward.
- `busywait  output  1`: high while a request is pending or in progress.

## Operation
- **State:** IDLE, BUSY, DONE; a 4-bit down-counter `cnt`; captured address and write data; a `wr` flag; a 64×32 array.
- **IDLE:**
  - `busywait = read | write`, combinational, so the requester sees a stall in the same cycle it asserts the request.
  - At a posedge with `read` or `write` high: capture `address` and `writedata`, set `wr = write`, load `cnt = LATENCY-1`, go to BUSY.
- **BUSY:**
  - `busywait = 1`.
  - At a posedge with `cnt != 0`: decrement `cnt`.
  - At a posedge with `cnt == 0`:
    - `wr = 1`: array[captured address] ← captured data.
    - `wr = 0`: `readdata` ← array[captured address].
    - Go to DONE.
- **DONE:**
  - `busywait = 0` for exactly one cycle.
  - At the next posedge go to IDLE unconditionally. `read`/`write` still high at that edge are ignored; this is required because the cache drops its request only on that edge.
- **Simultaneous `read` and `write`:** treated as a write. `readdata` is unchanged.
- **Input changes after capture:** changes to `address`/`writedata` during BUSY are ignored; only the captured copies are used.
- **`readdata` retention:** updated only on read completion. It holds its value across writes and idle periods.
- **Address range:** the full 6-bit range 0–63 is valid; there is no wrap or aliasing.
- **Reset (any time, including mid-access):**
  - State → IDLE; `cnt` → 0; `readdata` → 0; all 64 array words → 0.
  - `busywait` then follows `read | write`.
  - An aborted write does not reach the array.

## Timing
- **Request at posedge E0 (captured):**
  - `busywait` is high from the request assertion through edge E0+LATENCY.
  - The access completes at edge E0+LATENCY.
  - `busywait` is low and `readdata` is valid in the cycle after E0+LATENCY.
  - State returns to IDLE at E0+LATENCY+1.
- **Stall length:** with `LATENCY = 5`, the requester stalls for 6 cycles including the request cycle.
- **Back-to-back:** a new request can be captured at E0+LATENCY+2 at the earliest, because the DONE→IDLE edge does not capture.
- **`LATENCY = 1`:** access at E0+1, DONE for one cycle.
- **Output paths:** `readdata` is registered. `busywait` is a function of state plus `read`/`write` only, with no other combinational paths.

## Test plan
- **Write then read:**
  - Stimulus: write 0xDEADBEEF to block 3 at E0; after DONE, read block 3.
  - Required: `readdata` = 0xDEADBEEF in the cycle after the read's E0+5; `busywait` high for exactly 6 cycles on each access.
- **Latency sweep:**
  - Stimulus: LATENCY = 1, 5, 15.
  - Required: access completes at edge E0+LATENCY; DONE lasts exactly one cycle; no capture at the DONE→IDLE edge even with `read` held high.
- **Simultaneous `read` and `write`:**
  - Stimulus: block 10 holds 0x11223344 and `readdata` = 0xAAAAAAAA; assert both `read` and `write` with data 0x55667788.
  - Required: block 10 = 0x55667788; `readdata` stays 0xAAAAAAAA.
- **Reset mid-write:**
  - Stimulus: pulse RESET at E0+2 of a write of 0xFFFFFFFF to block 7; then read block 7.
  - Required: `busywait` = 0 and `readdata` = 0 immediately after RESET; the read returns 0.
- **Boundary addresses and changing inputs:**
  - Stimulus: write blocks 0 and 63 with distinct values; toggle `address`/`writedata` during BUSY.
  - Required: the captured values are stored; readback of both blocks is correct; blocks 1–62 remain 0.
- **Back-to-back reads:**
  - Stimulus: cache-style handshake (drop `read` on the edge after `busywait` falls) reading blocks 1, 2, 3.
  - Required: each read returns its block; the second capture is no earlier than E0+LATENCY+2.

Source files
------------

// File: rtl/block_memory.sv
// Main data memory answering block requests from the data cache: 64 x 32-bit blocks
// with a fixed access latency, stalling the requester on busywait.
module block_memory #(
    parameter int LATENCY = 5
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        read,
    input  logic        write,
    input  logic [5:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        busywait
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [5:0]  addr_q;
    logic [31:0] data_q;
    logic        wr;
    logic        request;
    logic        access_done;
    logic [31:0] mem [64];

    assign request     = read | write;
    assign access_done = (state == BUSY) && (cnt == 4'd0);

    // NOTE: sequential state uses non-blocking (<=) so every register samples the
    // pre-edge values of its peers; blocking here would create order-dependent races.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default before the case so that no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        busywait   = 1'b0;
        case (state)
            IDLE: begin
                busywait = request;
                if (request) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                busywait = 1'b1;
                if (cnt == 4'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // The cache drops its request on the edge leaving DONE, so it is not captured.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt    <= 4'd0;
            addr_q <= 6'd0;
            data_q <= 32'd0;
            wr     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        addr_q <= address;
                        data_q <= writedata;
                        wr     <= write;
                        cnt    <= CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // NOTE: the array is reset word by word, so it maps to flops rather than a RAM
    // macro; that is the price of guaranteeing all-zero contents after RESET.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= 32'd0;
            end
        end else if (access_done && wr) begin
            mem[addr_q] <= data_q;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            readdata <= 32'd0;
        end else if (access_done && !wr) begin
            readdata <= mem[addr_q];
        end
    end

endmodule

// File: tb/tb_block_memory.sv
// Randomized self-checking bench for block_memory at LATENCY 1, 5 and 15, checked
// against an array-based reference model of the memory contents and last read.
module tb_block_memory;

    logic        clk;
    logic        rst;
    logic        rd_s      [3];
    logic        wr_s      [3];
    logic [5:0]  addr_s    [3];
    logic [31:0] wdata_s   [3];
    logic [31:0] readdata_s[3];
    logic        busy_s    [3];

    logic [31:0] mem_m [3][64];
    logic [31:0] rd_m  [3];

    int n_checks;
    int n_fail;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        block_memory #(
            .LATENCY((g == 0) ? 1 : (g == 1) ? 5 : 15)
        ) dut (
            .CLK      (clk),
            .RESET    (rst),
            .read     (rd_s[g]),
            .write    (wr_s[g]),
            .address  (addr_s[g]),
            .writedata(wdata_s[g]),
            .readdata (readdata_s[g]),
            .busywait (busy_s[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat(input int k);
        return (k == 0) ? 1 : (k == 1) ? 5 : 15;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            rd_m[k] = 32'd0;
            for (int a = 0; a < 64; a++) begin
                mem_m[k][a] = 32'd0;
            end
        end
    endtask

    // One cache-style access: request asserted between edges, inputs scrambled once
    // captured, request dropped just after the edge that follows busywait falling.
    task automatic access(input int k, input logic r, input logic w,
                          input logic [5:0] a, input logic [31:0] d);
        int edges;
        rd_s[k]    = r;
        wr_s[k]    = w;
        addr_s[k]  = a;
        wdata_s[k] = d;
        #1;
        check("busy_on_request", 32'(busy_s[k]), 32'd1);
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            #1;
            addr_s[k]  = 6'($urandom);
            wdata_s[k] = $urandom;
        end while (busy_s[k] && edges < 40);
        if (w) begin
            mem_m[k][a] = d;
        end else if (r) begin
            rd_m[k] = mem_m[k][a];
        end
        check("busy_edges", 32'(edges), 32'(lat(k) + 1));
        check("readdata_done", readdata_s[k], rd_m[k]);
        @(posedge clk);
        #1;
        rd_s[k] = 1'b0;
        wr_s[k] = 1'b0;
        #1;
        check("no_capture_after_done", 32'(busy_s[k]), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            rd_s[k]    = 1'b0;
            wr_s[k]    = 1'b0;
            addr_s[k]  = 6'd0;
            wdata_s[k] = 32'd0;
        end
        rst = 1'b1;
        #13;
        for (int k = 0; k < 3; k++) begin
            check("reset_readdata", readdata_s[k], 32'd0);
            check("reset_busy", 32'(busy_s[k]), 32'd0);
        end
        #10;
        rst = 1'b0;

        // Write then read at every latency, plus back-to-back reads of blocks 1..3.
        for (int k = 0; k < 3; k++) begin
            access(k, 1'b0, 1'b1, 6'd3, 32'hDEADBEEF);
            access(k, 1'b1, 1'b0, 6'd3, 32'h0);
            access(k, 1'b0, 1'b1, 6'd1, 32'h0101_0101 * (k + 1));
            access(k, 1'b0, 1'b1, 6'd2, 32'h0202_0202 * (k + 1));
            for (int b = 1; b <= 3; b++) begin
                access(k, 1'b1, 1'b0, 6'(b), 32'h0);
            end
        end

        // Simultaneous read and write is a write; readdata must not move.
        access(1, 1'b0, 1'b1, 6'd10, 32'h11223344);
        access(1, 1'b0, 1'b1, 6'd20, 32'hAAAAAAAA);
        access(1, 1'b1, 1'b0, 6'd20, 32'h0);
        check("readdata_aa", readdata_s[1], 32'hAAAAAAAA);
        access(1, 1'b1, 1'b1, 6'd10, 32'h55667788);
        check("rw_keeps_readdata", readdata_s[1], 32'hAAAAAAAA);
        access(1, 1'b1, 1'b0, 6'd10, 32'h0);
        check("rw_stored", readdata_s[1], 32'h55667788);

        // Reset two edges into a write of block 7: the write must be lost.
        rd_s[1]    = 1'b0;
        wr_s[1]    = 1'b1;
        addr_s[1]  = 6'd7;
        wdata_s[1] = 32'hFFFFFFFF;
        repeat (3) @(posedge clk);
        #1;
        rst     = 1'b1;
        wr_s[1] = 1'b0;
        #1;
        check("reset_mid_busy", 32'(busy_s[1]), 32'd0);
        check("reset_mid_readdata", readdata_s[1], 32'd0);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("after_reset_busy", 32'(busy_s[1]), 32'd0);
        access(1, 1'b1, 1'b0, 6'd7, 32'h0);
        check("aborted_write_lost", readdata_s[1], 32'd0);

        // Boundary blocks, then sweep every block to confirm 1..62 stayed zero.
        access(1, 1'b0, 1'b1, 6'd0, 32'hC0FFEE00);
        access(1, 1'b0, 1'b1, 6'd63, 32'h600DF00D);
        for (int a = 0; a < 64; a++) begin
            access(1, 1'b1, 1'b0, 6'(a), 32'h0);
        end

        // Random traffic, addresses biased to a small window so reads hit written data.
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 40; n++) begin
                int unsigned op;
                logic [5:0]  a;
                op = $urandom_range(0, 3);
                a  = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 7)) : 6'($urandom);
                access(k, (op == 0 || op == 2 || op == 3), (op == 1 || op == 2), a, $urandom);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
